// File: rtl/sha256_round_ctrl.sv
// Control sequencer for the SHA-256 compression datapath: block intake, 64-round
// stepping, hash update strobe and digest hand-off with multi-block chaining.
module sha256_round_ctrl #(
    parameter int ROUNDS    = 64,
    parameter int CNT_W     = 6,
    parameter int MSG_WORDS = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             blk_valid,
    input  logic             blk_last,
    output logic             blk_ready,
    input  logic             abort,
    output logic             ld_en,
    output logic             iv_sel,
    output logic             reg_en,
    output logic [CNT_W-1:0] round_idx,
    output logic             w_sched_sel,
    output logic             hash_upd_en,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic             busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_ROUND  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;
    localparam int         N_STATES = 5;

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] MSG_LIMIT  = CNT_W'(MSG_WORDS);

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] round_reg, round_next;
    logic             first_blk_reg, first_blk_next;
    logic             last_q_reg, last_q_next;
    logic [N_STATES-1:0] state_hot;

    // One-hot decode of the registered state; every strobe is a pure function of it.
    generate
        for (genvar gi = 0; gi < N_STATES; gi++) begin : g_state_dec
            assign state_hot[gi] = (state_reg == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        round_next     = '0;
        first_blk_next = first_blk_reg;
        last_q_next    = last_q_reg;
        if (abort) begin
            state_next     = S_IDLE;
            first_blk_next = 1'b1;
            last_q_next    = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (blk_valid) begin
                        last_q_next = blk_last;
                        state_next  = S_LOAD;
                    end
                end
                S_LOAD: state_next = S_ROUND;
                S_ROUND: begin
                    if (round_reg == LAST_ROUND) begin
                        state_next = S_UPDATE;
                    end else begin
                        round_next = round_reg + CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    first_blk_next = 1'b0;
                    state_next     = last_q_reg ? S_OUT : S_IDLE;
                end
                S_OUT: begin
                    if (digest_ready) begin
                        first_blk_next = 1'b1;
                        state_next     = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            round_reg     <= '0;
            first_blk_reg <= 1'b1;
            last_q_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            round_reg     <= round_next;
            first_blk_reg <= first_blk_next;
            last_q_reg    <= last_q_next;
        end
    end

    assign blk_ready    = state_hot[S_IDLE];
    assign ld_en        = state_hot[S_LOAD];
    assign iv_sel       = state_hot[S_LOAD] & first_blk_reg;
    assign reg_en       = state_hot[S_ROUND];
    assign round_idx    = round_reg;
    assign w_sched_sel  = state_hot[S_ROUND] & (round_reg >= MSG_LIMIT);
    assign hash_upd_en  = state_hot[S_UPDATE];
    assign digest_valid = state_hot[S_OUT];
    assign busy         = ~state_hot[S_IDLE];

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: a latency-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sha256_round_ctrl;

    logic       CLK;
    logic       RST;
    logic       blk_valid;
    logic       blk_last;
    logic       blk_ready;
    logic       abort;
    logic       ld_en;
    logic       iv_sel;
    logic       reg_en;
    logic [5:0] round_idx;
    logic       w_sched_sel;
    logic       hash_upd_en;
    logic       digest_valid;
    logic       digest_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    sha256_round_ctrl #(.ROUNDS(64), .CNT_W(6), .MSG_WORDS(16)) dut (
        .CLK(CLK), .RST(RST),
        .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
        .abort(abort), .ld_en(ld_en), .iv_sel(iv_sel), .reg_en(reg_en),
        .round_idx(round_idx), .w_sched_sel(w_sched_sel), .hash_upd_en(hash_upd_en),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    // Reference model: age = cycles since the block was accepted (-1 idle, 67 = digest pending).
    int m_age   = -1;
    bit m_first = 1;
    bit m_last  = 0;

    always @(posedge CLK) begin
        if (RST || abort) begin
            m_age   <= -1;
            m_first <= 1;
            m_last  <= 0;
        end else if (m_age == -1) begin
            if (blk_valid) begin
                m_age  <= 1;
                m_last <= blk_last;
            end
        end else if (m_age < 66) begin
            m_age <= m_age + 1;
        end else if (m_age == 66) begin
            m_first <= 0;
            m_age   <= m_last ? 67 : -1;
        end else if (digest_ready) begin
            m_first <= 1;
            m_age   <= -1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("m_blk_ready", 32'(blk_ready), 32'(m_age == -1));
            check("m_ld_en", 32'(ld_en), 32'(m_age == 1));
            check("m_iv_sel", 32'(iv_sel), 32'(m_age == 1 && m_first));
            check("m_reg_en", 32'(reg_en), 32'(m_age >= 2 && m_age <= 65));
            check("m_round_idx", 32'(round_idx), (m_age >= 2 && m_age <= 65) ? 32'(m_age - 2) : 32'd0);
            check("m_w_sched_sel", 32'(w_sched_sel), 32'(m_age >= 18 && m_age <= 65));
            check("m_hash_upd_en", 32'(hash_upd_en), 32'(m_age == 66));
            check("m_digest_valid", 32'(digest_valid), 32'(m_age == 67));
            check("m_busy", 32'(busy), 32'(m_age != -1));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Hands over one block from IDLE and follows it until the digest or the next blk_ready.
    task automatic send_and_measure(input bit last, output int lat, output int nreg,
                                    output int wrise, output bit iv_seen);
        lat = 0; nreg = 0; wrise = -1; iv_seen = 0;
        blk_valid = 1; blk_last = last;
        tick();
        blk_valid = 0; blk_last = 0;
        for (int k = 1; k <= 200; k++) begin
            if (ld_en && iv_sel) iv_seen = 1;
            if (reg_en) begin
                nreg++;
                if (w_sched_sel && wrise < 0) wrise = int'(round_idx);
            end
            if (last ? digest_valid : blk_ready) begin
                lat = k;
                break;
            end
            tick();
        end
        $display("block last=%0d latency=%0d rounds=%0d wsched_from=%0d iv=%0d",
                 last, lat, nreg, wrise, iv_seen);
    endtask

    task automatic wait_round(input int r);
        for (int k = 0; k < 200; k++) begin
            if (reg_en && int'(round_idx) == r) break;
            tick();
        end
        check("reach_round", 32'(round_idx), 32'(r));
    endtask

    task automatic finish_digest();
        for (int k = 0; k < 100; k++) begin
            if (digest_valid) break;
            tick();
        end
        check("digest_valid_wait", 32'(digest_valid), 32'd1);
        digest_ready = 1;
        tick();
        digest_ready = 0;
        check("ready_after_hs", 32'(blk_ready), 32'd1);
        $display("digest handshake done at %0t", $time);
    endtask

    int  lat, nreg, wrise;
    bit  iv_seen;

    initial begin
        RST = 1; blk_valid = 0; blk_last = 0; abort = 0; digest_ready = 0;
        tick(); tick();
        RST = 0;
        chk_en = 1;
        check("reset_blk_ready", 32'(blk_ready), 32'd1);
        check("reset_round", 32'(round_idx), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Reset in the middle of the rounds
        blk_valid = 1; blk_last = 1;
        tick();
        blk_valid = 0; blk_last = 0;
        wait_round(20);
        RST = 1;
        tick(); tick();
        RST = 0;
        check("rst_mid_ready", 32'(blk_ready), 32'd1);
        check("rst_mid_round", 32'(round_idx), 32'd0);
        check("rst_mid_reg_en", 32'(reg_en), 32'd0);
        $display("reset mid-round done");

        // Single-block message
        send_and_measure(1, lat, nreg, wrise, iv_seen);
        check("single_latency", 32'(lat), 32'd67);
        check("single_rounds", 32'(nreg), 32'd64);
        check("single_wsched", 32'(wrise), 32'd16);
        check("single_iv", 32'(iv_seen), 32'd1);
        finish_digest();

        // Two-block message: chaining, no IV on the second block
        send_and_measure(0, lat, nreg, wrise, iv_seen);
        check("blk1_latency", 32'(lat), 32'd67);
        check("blk1_iv", 32'(iv_seen), 32'd1);
        check("blk1_no_digest", 32'(digest_valid), 32'd0);
        send_and_measure(1, lat, nreg, wrise, iv_seen);
        check("blk2_latency", 32'(lat), 32'd67);
        check("blk2_iv", 32'(iv_seen), 32'd0);
        finish_digest();

        // Digest backpressure with a new block waiting
        send_and_measure(1, lat, nreg, wrise, iv_seen);
        blk_valid = 1; blk_last = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_digest_valid", 32'(digest_valid), 32'd1);
            check("bp_blk_ready", 32'(blk_ready), 32'd0);
        end
        digest_ready = 1;
        tick();
        digest_ready = 0;
        check("bp_after_hs_ld", 32'(ld_en), 32'd0);
        check("bp_after_hs_ready", 32'(blk_ready), 32'd1);
        tick();
        blk_valid = 0; blk_last = 0;
        check("bp_accept_ld", 32'(ld_en), 32'd1);
        check("bp_accept_iv", 32'(iv_sel), 32'd1);
        finish_digest();

        // Abort mid-round, then a clean block must start from the IV again
        blk_valid = 1; blk_last = 1;
        tick();
        blk_valid = 0; blk_last = 0;
        wait_round(40);
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(blk_ready), 32'd1);
        for (int k = 0; k < 30; k++) tick();
        send_and_measure(1, lat, nreg, wrise, iv_seen);
        check("post_abort_latency", 32'(lat), 32'd67);
        check("post_abort_iv", 32'(iv_seen), 32'd1);
        finish_digest();

        // abort together with blk_valid in IDLE
        abort = 1; blk_valid = 1;
        check("abort_idle_ready", 32'(blk_ready), 32'd1);
        tick();
        abort = 0; blk_valid = 0;
        check("abort_idle_ld", 32'(ld_en), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        tick(); tick();
        $display("abort in idle done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
